// File: rtl/apb_gpio_arb_pkg.sv
// Shared definitions for the two-master APB arbiter in front of the GPIO slave.
package apb_gpio_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int GRANT_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Master index reached by stepping forward from cur, wrapping round the ring.
  function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] cur,
                                                  input int step);
    return GRANT_W'((int'(cur) + step) % NUM_MASTERS);
  endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Round-robin pick: searches the request vector starting just after the
// last-granted master, so a lone requester wins at once and simultaneous
// requesters take turns.
module apb_rr_arb
  import apb_gpio_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GRANT_W-1:0]     last_grant,
  output logic [GRANT_W-1:0]     grant
);

  logic found;

  // Walk the ring once from last_grant+1; the first active request wins.
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!found && req[next_idx(last_grant, k)]) begin
        grant = next_idx(last_grant, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_gpio_arb.sv
// Two APB masters sharing one APB GPIO slave. A small IDLE/SETUP/ACCESS
// controller owns the slave bus; the granted master's request is steered to
// the slave and the slave's response is returned only to that master, only in
// the completion cycle. Everyone else sees PREADY low and simply waits.
module apb_gpio_arb
  import apb_gpio_arb_pkg::*;
#(
  parameter int PDATA_SIZE = 8,
  parameter int PADDR_SIZE = 4
) (
  input  logic                                PCLK,
  input  logic                                PRESET,
  input  logic [NUM_MASTERS-1:0]              m_PSEL,
  input  logic [NUM_MASTERS-1:0]              m_PENABLE,
  input  logic [NUM_MASTERS-1:0]              m_PWRITE,
  input  logic [NUM_MASTERS*PADDR_SIZE-1:0]   m_PADDR,
  input  logic [NUM_MASTERS*PDATA_SIZE/8-1:0] m_PSTRB,
  input  logic [NUM_MASTERS*PDATA_SIZE-1:0]   m_PWDATA,
  output logic [NUM_MASTERS*PDATA_SIZE-1:0]   m_PRDATA,
  output logic [NUM_MASTERS-1:0]              m_PREADY,
  output logic [NUM_MASTERS-1:0]              m_PSLVERR,
  output logic                                s_PSEL,
  output logic                                s_PENABLE,
  output logic                                s_PWRITE,
  output logic [PADDR_SIZE-1:0]               s_PADDR,
  output logic [PDATA_SIZE/8-1:0]             s_PSTRB,
  output logic [PDATA_SIZE-1:0]               s_PWDATA,
  input  logic [PDATA_SIZE-1:0]               s_PRDATA,
  input  logic                                s_PREADY,
  input  logic                                s_PSLVERR
);

  localparam int STRB_SIZE = PDATA_SIZE / 8;

  state_t             state;
  logic [GRANT_W-1:0] gnt;
  logic [GRANT_W-1:0] last_gnt;
  logic [GRANT_W-1:0] arb_gnt;
  logic               active;
  logic               complete;

  // Phase of each master is tracked by the controller itself, so the
  // masters' own PENABLE lines carry no extra information here.
  logic unused_penable;
  assign unused_penable = ^m_PENABLE;

  apb_rr_arb u_rr_arb (
    .req        (m_PSEL),
    .last_grant (last_gnt),
    .grant      (arb_gnt)
  );

  // Controller: grant in IDLE, one SETUP cycle, ACCESS until the slave is ready.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      gnt       <= '0;
      last_gnt  <= GRANT_W'(NUM_MASTERS - 1);
      s_PSEL    <= 1'b0;
      s_PENABLE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_PSEL) begin
            gnt    <= arb_gnt;
            state  <= SETUP;
            s_PSEL <= 1'b1;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          s_PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (s_PREADY) begin
            last_gnt  <= gnt;
            state     <= IDLE;
            s_PSEL    <= 1'b0;
            s_PENABLE <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          s_PSEL    <= 1'b0;
          s_PENABLE <= 1'b0;
        end
      endcase
    end
  end

  assign active   = (state != IDLE);
  assign complete = (state == ACCESS) && s_PREADY;

  // Steer the granted master's request fields onto the slave bus while busy.
  always_comb begin
    s_PADDR  = '0;
    s_PWRITE = 1'b0;
    s_PSTRB  = '0;
    s_PWDATA = '0;
    if (active) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (gnt == GRANT_W'(i)) begin
          s_PADDR  = m_PADDR[i*PADDR_SIZE +: PADDR_SIZE];
          s_PWRITE = m_PWRITE[i];
          s_PSTRB  = m_PSTRB[i*STRB_SIZE +: STRB_SIZE];
          s_PWDATA = m_PWDATA[i*PDATA_SIZE +: PDATA_SIZE];
        end
      end
    end
  end

  // Return the response to the granted master in the completion cycle only;
  // a master that has already let go of PSEL gets nothing back.
  always_comb begin
    m_PREADY  = '0;
    m_PSLVERR = '0;
    m_PRDATA  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (complete && (gnt == GRANT_W'(i)) && m_PSEL[i]) begin
        m_PREADY[i]                         = 1'b1;
        m_PSLVERR[i]                        = s_PSLVERR;
        m_PRDATA[i*PDATA_SIZE +: PDATA_SIZE] = s_PRDATA;
      end
    end
  end

endmodule
